// File: rtl/wb_downsizer.sv
// Wishbone width bridge: one wide classic request becomes a run of 32-bit beats.
// Unselected lanes are skipped; read beats are gathered into one wide response.
module wb_downsizer #(
    parameter int CACHE_WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              s_adr_i,
    input  logic [CACHE_WIDTH-1:0]   s_dat_i,
    output logic [CACHE_WIDTH-1:0]   s_dat_o,
    input  logic                     s_we_i,
    input  logic [CACHE_WIDTH/8-1:0] s_sel_i,
    input  logic                     s_stb_i,
    input  logic                     s_cyc_i,
    output logic                     s_ack_o,
    output logic                     s_err_o,
    output logic                     s_rty_o,
    output logic [31:0]              m_adr_o,
    output logic [31:0]              m_dat_o,
    input  logic [31:0]              m_dat_i,
    output logic                     m_we_o,
    output logic [3:0]               m_sel_o,
    output logic                     m_stb_o,
    output logic                     m_cyc_o,
    input  logic                     m_ack_i,
    input  logic                     m_err_i,
    input  logic                     m_rty_i
);
    localparam int BEATS     = CACHE_WIDTH / 32;
    localparam int SEL_WIDTH = CACHE_WIDTH / 8;
    localparam int AW        = $clog2(SEL_WIDTH);
    localparam int KW        = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, BEAT, DONE, FAIL} state_t;

    state_t                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [31:0]            base_q, base_d;
    logic                   we_q, we_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [CACHE_WIDTH-1:0] wdat_q, wdat_d;
    logic [CACHE_WIDTH-1:0] buf_q, buf_d;
    logic [31:0]            m_adr_q, m_adr_d;
    logic [31:0]            m_dat_q, m_dat_d;
    logic [3:0]             m_sel_q, m_sel_d;
    logic                   m_we_q, m_we_d;
    logic                   m_stb_q, m_stb_d;
    logic                   s_ack_q, s_ack_d;
    logic                   s_err_q, s_err_d;
    logic                   s_rty_q, s_rty_d;
    logic [BEATS-1:0]       rest;
    logic                   beat_d;
    logic                   unused_adr_lo;

    assign unused_adr_lo = ^s_adr_i[AW-1:0];

    function automatic logic [BEATS-1:0] lane_nz(input logic [SEL_WIDTH-1:0] sel);
        lane_nz = '0;
        for (int i = 0; i < BEATS; i++) lane_nz[i] = |sel[4*i +: 4];
    endfunction

    function automatic logic [KW-1:0] lowest(input logic [BEATS-1:0] m);
        lowest = '0;
        for (int i = BEATS - 1; i >= 0; i--) if (m[i]) lowest = KW'(i);
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        base_d  = base_q;
        we_d    = we_q;
        sel_d   = sel_q;
        wdat_d  = wdat_q;
        buf_d   = buf_q;
        s_err_d = 1'b0;
        s_rty_d = 1'b0;
        rest    = '0;
        // lanes still pending after the current one
        for (int i = 0; i < BEATS; i++)
            rest[i] = lane_nz(sel_q)[i] && (KW'(i) > k_q);
        unique case (state_q)
            IDLE: begin
                if (s_cyc_i && s_stb_i) begin
                    base_d = {s_adr_i[31:AW], {AW{1'b0}}};
                    we_d   = s_we_i;
                    sel_d  = s_sel_i;
                    wdat_d = s_dat_i;
                    buf_d  = '0;
                    if (|s_sel_i) begin
                        state_d = BEAT;
                        k_d     = lowest(lane_nz(s_sel_i));
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BEAT: begin
                if (!s_cyc_i) begin
                    state_d = IDLE;
                end else if (m_err_i || m_rty_i) begin
                    state_d = FAIL;
                    s_err_d = m_err_i;
                    s_rty_d = !m_err_i;
                end else if (m_ack_i) begin
                    if (!we_q) buf_d[{k_q, 5'b0} +: 32] = m_dat_i;
                    if (|rest) k_d = lowest(rest);
                    else state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            FAIL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are registered copies of what the next state drives
        beat_d  = (state_d == BEAT);
        m_adr_d = beat_d ? base_d + {{(30-KW){1'b0}}, k_d, 2'b00} : m_adr_q;
        m_dat_d = beat_d ? wdat_d[{k_d, 5'b0} +: 32] : '0;
        m_sel_d = beat_d ? sel_d[{k_d, 2'b0} +: 4] : '0;
        m_we_d  = beat_d && we_d;
        m_stb_d = beat_d;
        s_ack_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            base_q  <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            wdat_q  <= '0;
            buf_q   <= '0;
            m_adr_q <= '0;
            m_dat_q <= '0;
            m_sel_q <= '0;
            m_we_q  <= 1'b0;
            m_stb_q <= 1'b0;
            s_ack_q <= 1'b0;
            s_err_q <= 1'b0;
            s_rty_q <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            buf_q   <= buf_d;
            m_adr_q <= m_adr_d;
            m_dat_q <= m_dat_d;
            m_sel_q <= m_sel_d;
            m_we_q  <= m_we_d;
            m_stb_q <= m_stb_d;
            s_ack_q <= s_ack_d;
            s_err_q <= s_err_d;
            s_rty_q <= s_rty_d;
        end
    end

    assign s_dat_o = buf_q;
    assign s_ack_o = s_ack_q;
    assign s_err_o = s_err_q;
    assign s_rty_o = s_rty_q;
    assign m_adr_o = m_adr_q;
    assign m_dat_o = m_dat_q;
    assign m_sel_o = m_sel_q;
    assign m_we_o  = m_we_q;
    assign m_stb_o = m_stb_q;
    assign m_cyc_o = m_stb_q;

endmodule

// File: tb/tb_wb_downsizer.sv
// Bench for wb_downsizer: vector table plus scoreboards for beats and
// upstream terminations, with a slave model that can stall or fault.
module tb_wb_downsizer;
    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  s_adr_i;
    logic [127:0] s_dat_i;
    logic [127:0] s_dat_o;
    logic         s_we_i;
    logic [15:0]  s_sel_i;
    logic         s_stb_i, s_cyc_i;
    logic         s_ack_o, s_err_o, s_rty_o;
    logic [31:0]  m_adr_o, m_dat_o, m_dat_i;
    logic         m_we_o;
    logic [3:0]   m_sel_o;
    logic         m_stb_o, m_cyc_o;
    logic         m_ack_i, m_err_i, m_rty_i;

    always #5 clk = ~clk;

    wb_downsizer #(.CACHE_WIDTH(128)) dut (
        .clk(clk), .rst(rst),
        .s_adr_i(s_adr_i), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o),
        .s_we_i(s_we_i), .s_sel_i(s_sel_i),
        .s_stb_i(s_stb_i), .s_cyc_i(s_cyc_i),
        .s_ack_o(s_ack_o), .s_err_o(s_err_o), .s_rty_o(s_rty_o),
        .m_adr_o(m_adr_o), .m_dat_o(m_dat_o), .m_dat_i(m_dat_i),
        .m_we_o(m_we_o), .m_sel_o(m_sel_o),
        .m_stb_o(m_stb_o), .m_cyc_o(m_cyc_o),
        .m_ack_i(m_ack_i), .m_err_i(m_err_i), .m_rty_i(m_rty_i)
    );

    typedef struct packed {
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        we;
    } beat_t;

    typedef struct {
        logic [1:0]   term;
        logic [127:0] dat;
        int           lat;
        int           stb;
    } rsp_t;

    typedef struct {
        logic [31:0]  adr;
        logic [15:0]  sel;
        logic         we;
        logic [127:0] wdat;
        int           waits;
        int           err_b;
        int           rty_b;
        logic [1:0]   term;
        int           lat;
        int           stb;
        logic [127:0] dat;
    } vec_t;

    beat_t beat_q[$];
    rsp_t  rsp_q[$];
    vec_t  vecs[$];
    int    errors = 0;
    int    checks = 0;
    int    ncyc = 0;
    int    req_base = 0;
    int    cyc_cnt, stb_cnt;
    int    waits = 0, err_beat = 0, rty_beat = 0;
    int    wcnt = 0, beat_no = 0;
    logic  term_seen;
    logic  found;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] a);
        return 32'h11111111 * (32'(a[3:2]) + 32'd1);
    endfunction

    // one clock: slave and upstream monitor act at the falling edge
    task automatic tick();
        logic [1:0] t;
        beat_t b, e;
        rsp_t r;
        @(negedge clk);
        ncyc++;
        if (m_cyc_o) cyc_cnt++;
        if (m_stb_o) stb_cnt++;
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_rty_i = 1'b0;
        m_dat_i = 32'hDEADBEEF;
        if (!m_cyc_o) beat_no = 0;
        if (!m_stb_o) wcnt = 0;
        else if (wcnt < waits) wcnt++;
        else begin
            wcnt = 0;
            beat_no++;
            b = '{m_adr_o, m_sel_o, m_dat_o, m_we_o};
            if (beat_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat: got unexpected beat %h required none", b);
            end else begin
                e = beat_q.pop_front();
                chk("beat", 128'(b), 128'(e));
            end
            if (beat_no == err_beat) m_err_i = 1'b1;
            if (beat_no == rty_beat) m_rty_i = 1'b1;
            if (!m_err_i && !m_rty_i) begin
                m_ack_i = 1'b1;
                m_dat_i = rd_data(m_adr_o);
            end
        end
        t = s_ack_o ? 2'd1 : s_err_o ? 2'd2 : s_rty_o ? 2'd3 : 2'd0;
        if (t != 2'd0) begin
            term_seen = 1'b1;
            if (rsp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL term: got unexpected termination %0d required none", t);
            end else begin
                r = rsp_q.pop_front();
                chk("term", 128'(t), 128'(r.term));
                chk("latency", 128'(ncyc - req_base), 128'(r.lat));
                chk("stb_cycles", 128'(stb_cnt), 128'(r.stb));
                chk("cyc_cycles", 128'(cyc_cnt), 128'(r.stb));
                if (t == 2'd1) chk("rdata", s_dat_o, r.dat);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] adr, input logic [15:0] sel,
                         input logic we, input logic [127:0] wdat);
        s_adr_i   = adr;
        s_sel_i   = sel;
        s_we_i    = we;
        s_dat_i   = wdat;
        s_cyc_i   = 1'b1;
        s_stb_i   = 1'b1;
        req_base  = ncyc + 1;
        cyc_cnt   = 0;
        stb_cnt   = 0;
        term_seen = 1'b0;
    endtask

    task automatic stop();
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
        s_sel_i = '0;
        s_dat_i = '0;
    endtask

    task automatic push_beats(input vec_t v);
        int n;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (|v.sel[4*k +: 4]) begin
                n++;
                beat_q.push_back('{{v.adr[31:4], 4'h0} + 32'(4 * k),
                                   v.sel[4*k +: 4], v.wdat[32*k +: 32], v.we});
                if (n == v.err_b || n == v.rty_b) break;
            end
        end
    endtask

    task automatic run(input vec_t v);
        push_beats(v);
        rsp_q.push_back('{v.term, v.dat, v.lat, v.stb});
        waits    = v.waits;
        err_beat = v.err_b;
        rty_beat = v.rty_b;
        start(v.adr, v.sel, v.we, v.wdat);
        for (int i = 0; i < 60 && !term_seen; i++) tick();
        chk("timeout", 128'(term_seen), 128'(1));
        stop();
        tick();
        tick();
        chk("beats_left", 128'(beat_q.size()), 128'(0));
        beat_q.delete();
        rsp_q.delete();
    endtask

    localparam logic [127:0] RD4 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] WA  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [127:0] WD  = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
    localparam logic [127:0] RL1 = 128'h00000000_00000000_22222222_00000000;

    initial begin
        rst = 1'b0;
        stop();
        m_ack_i = 1'b0;
        m_err_i = 1'b0;
        m_rty_i = 1'b0;
        m_dat_i = '0;
        vecs.push_back('{32'h1008, 16'hFFFF, 1'b0, 128'h0, 0, 0, 0, 2'd1, 5, 4, RD4});
        vecs.push_back('{32'h2004, 16'h0F0F, 1'b1, WA, 0, 0, 0, 2'd1, 3, 2, 128'h0});
        vecs.push_back('{32'h3000, 16'h0000, 1'b0, 128'h0, 0, 0, 0, 2'd1, 1, 0, 128'h0});
        vecs.push_back('{32'h1000, 16'hFFFF, 1'b0, WD, 0, 2, 0, 2'd2, 3, 2, 128'h0});
        vecs.push_back('{32'h1000, 16'hFFFF, 1'b0, 128'h0, 2, 0, 0, 2'd1, 13, 12, RD4});
        vecs.push_back('{32'h3000, 16'hF000, 1'b0, 128'h0, 0, 0, 1, 2'd3, 2, 1, 128'h0});
        vecs.push_back('{32'h4000, 16'h0030, 1'b0, 128'h0, 0, 0, 0, 2'd1, 2, 1, RL1});
        vecs.push_back('{32'h7000, 16'hF00F, 1'b1, WD, 1, 0, 0, 2'd1, 5, 4, 128'h0});
        vecs.push_back('{32'h8000, 16'h00FF, 1'b0, 128'h0, 0, 1, 1, 2'd2, 2, 1, 128'h0});

        repeat (2) @(posedge clk);
        #1;
        chk("reset_m", 128'({m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o}), 128'h0);
        chk("reset_s", 128'({s_ack_o, s_err_o, s_rty_o}), 128'h0);
        chk("reset_dat", s_dat_o, 128'h0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

        // upstream abort during beat 2, coincident with the slave ack
        waits = 0;
        err_beat = 0;
        rty_beat = 0;
        beat_q.push_back('{32'h5000, 4'hF, 32'h0, 1'b0});
        beat_q.push_back('{32'h5004, 4'hF, 32'h0, 1'b0});
        start(32'h5000, 16'hFFFF, 1'b0, 128'h0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            found = m_stb_o && (m_adr_o == 32'h5004);
        end
        chk("abort_beat2_seen", 128'(found), 128'(1));
        stop();
        tick();
        chk("abort_cyc", 128'({m_cyc_o, m_stb_o}), 128'h0);
        repeat (3) tick();
        chk("abort_beats", 128'(beat_q.size()), 128'(0));
        beat_q.delete();
        run(vecs[0]);

        // asynchronous reset during beat 3
        waits = 2;
        err_beat = 0;
        rty_beat = 0;
        for (int k = 0; k < 4; k++)
            beat_q.push_back('{32'h6000 + 32'(4 * k), 4'hF, 32'h0, 1'b0});
        start(32'h6000, 16'hFFFF, 1'b0, 128'h0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = m_stb_o && (m_adr_o == 32'h6008);
        end
        chk("reset_beat3_seen", 128'(found), 128'(1));
        #1 rst = 1'b0;
        #1;
        chk("areset_m", 128'({m_adr_o, m_dat_o, m_we_o, m_sel_o, m_stb_o, m_cyc_o}), 128'h0);
        chk("areset_s", 128'({s_ack_o, s_err_o, s_rty_o}), 128'h0);
        chk("areset_dat", s_dat_o, 128'h0);
        #1 rst = 1'b1;
        stop();
        repeat (3) tick();
        beat_q.delete();
        vecs[0].adr = 32'h6000;
        run(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
